// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec
// Brief    : Execute stage. Single-cycle ALU ops plus iterative MUL/DIV/MOD.
// Revision : 1.0
// ============================================================================
module alu_exec #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] temp1,
    input  logic [WIDTH-1:0] temp2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_v,
    output logic             err
);

    localparam int                 c_CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(WIDTH - 1);
    localparam logic [4:0]         c_OP_ADD = 5'b00100;
    localparam logic [4:0]         c_OP_SUB = 5'b00101;
    localparam logic [4:0]         c_OP_AND = 5'b00110;
    localparam logic [4:0]         c_OP_OR  = 5'b00111;
    localparam logic [4:0]         c_OP_XOR = 5'b01000;
    localparam logic [4:0]         c_OP_MUL = 5'b01001;
    localparam logic [4:0]         c_OP_DIV = 5'b01010;
    localparam logic [4:0]         c_OP_MOD = 5'b01011;
    localparam logic [4:0]         c_OP_CMP = 5'b01100;
    localparam logic [4:0]         c_OP_NOT = 5'b01101;
    localparam logic [4:0]         c_OP_INC = 5'b01111;
    localparam logic [4:0]         c_OP_DEC = 5'b10000;
    localparam logic [4:0]         c_OP_SHL = 5'b10001;
    localparam logic [4:0]         c_OP_SHR = 5'b10010;
    localparam logic [4:0]         c_OP_PAS = 5'b10011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [4:0]         r_op;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_zn;
    logic               w_c;
    logic               w_v;
    logic               w_err;
    logic               w_illegal;
    logic               w_iter;

    always_comb begin
        w_sum     = {1'b0, temp1} + {1'b0, temp2};
        w_diff    = {1'b0, temp1} - {1'b0, temp2};
        w_res     = '0;
        w_hi      = '0;
        w_c       = 1'b0;
        w_v       = 1'b0;
        w_err     = 1'b0;
        w_illegal = 1'b0;
        w_iter    = 1'b0;
        case (opcode)
            c_OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (temp1[WIDTH-1] == temp2[WIDTH-1]) && (w_sum[WIDTH-1] != temp1[WIDTH-1]);
            end
            c_OP_SUB, c_OP_CMP: begin
                w_res = (opcode == c_OP_CMP) ? temp1 : w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (temp1[WIDTH-1] != temp2[WIDTH-1]) && (w_diff[WIDTH-1] != temp1[WIDTH-1]);
            end
            c_OP_AND: w_res = temp1 & temp2;
            c_OP_OR:  w_res = temp1 | temp2;
            c_OP_XOR: w_res = temp1 ^ temp2;
            c_OP_NOT: w_res = ~temp1;
            c_OP_PAS: w_res = temp1;
            c_OP_MUL: w_iter = 1'b1;
            c_OP_DIV, c_OP_MOD: begin
                if (temp2 == '0) begin
                    w_res = '1;
                    w_hi  = temp1;
                    w_err = 1'b1;
                end else begin
                    w_iter = 1'b1;
                end
            end
            c_OP_INC: begin
                w_res = temp1 + WIDTH'(1);
                w_c   = &temp1;
                w_v   = (temp1 == {1'b0, {(WIDTH-1){1'b1}}});
            end
            c_OP_DEC: begin
                w_res = temp1 - WIDTH'(1);
                w_c   = (temp1 == '0);
                w_v   = (temp1 == {1'b1, {(WIDTH-1){1'b0}}});
            end
            c_OP_SHL: begin
                w_res = {temp1[WIDTH-2:0], 1'b0};
                w_c   = temp1[WIDTH-1];
            end
            c_OP_SHR: begin
                w_res = {1'b0, temp1[WIDTH-1:1]};
                w_c   = temp1[0];
            end
            default: begin
                w_err     = 1'b1;
                w_illegal = 1'b1;
            end
        endcase
        // CMP reports Z/N of the difference while returning A unchanged
        w_zn = (opcode == c_OP_CMP) ? w_diff[WIDTH-1:0] : w_res;
    end

    logic [WIDTH:0]   w_mac;
    logic [WIDTH:0]   w_rsh;
    logic [WIDTH-1:0] w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_nxt_acc;
    logic [WIDTH-1:0] w_nxt_q;
    logic [WIDTH-1:0] w_fin_res;
    logic [WIDTH-1:0] w_fin_hi;

    // r_acc holds the product high half / partial remainder, r_q the
    // multiplier-then-product low half / dividend-then-quotient.
    always_comb begin
        w_mac   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
        w_rsh   = {r_acc, r_q[WIDTH-1]};
        w_ge    = (w_rsh >= {1'b0, r_b});
        w_trial = w_rsh[WIDTH-1:0] - r_b;
        if (r_op == c_OP_MUL) begin
            w_nxt_acc = w_mac[WIDTH:1];
            w_nxt_q   = {w_mac[0], r_q[WIDTH-1:1]};
        end else begin
            w_nxt_acc = w_ge ? w_trial : w_rsh[WIDTH-1:0];
            w_nxt_q   = {r_q[WIDTH-2:0], w_ge};
        end
        if (r_op == c_OP_MOD) begin
            w_fin_res = w_nxt_acc;
            w_fin_hi  = w_nxt_q;
        end else if (r_op == c_OP_MUL) begin
            w_fin_res = w_nxt_q;
            w_fin_hi  = w_nxt_acc;
        end else begin
            w_fin_res = w_nxt_q;
            w_fin_hi  = w_nxt_acc;
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            result    <= '0;
            result_hi <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op  <= opcode;
                        r_b   <= temp2;
                        r_cnt <= '0;
                        if (w_iter) begin
                            r_acc   <= '0;
                            r_q     <= temp1;
                            r_state <= S_CALC;
                        end else begin
                            result    <= w_res;
                            result_hi <= w_hi;
                            flag_z    <= (w_zn == '0) && !w_illegal;
                            flag_n    <= w_zn[WIDTH-1];
                            flag_c    <= w_c;
                            flag_v    <= w_v;
                            err       <= w_err;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_nxt_acc;
                    r_q   <= w_nxt_q;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        result    <= w_fin_res;
                        result_hi <= w_fin_hi;
                        flag_z    <= (w_fin_res == '0);
                        flag_n    <= w_fin_res[WIDTH-1];
                        flag_c    <= 1'b0;
                        flag_v    <= 1'b0;
                        err       <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_alu_exec
// Brief    : Randomised self-checking bench for alu_exec with arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_alu_exec;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [4:0]       opcode;
    logic [WIDTH-1:0] temp1;
    logic [WIDTH-1:0] temp2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             flag_z;
    logic             flag_c;
    logic             flag_n;
    logic             flag_v;
    logic             err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_exec #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opcode    (opcode),
        .temp1     (temp1),
        .temp2     (temp2),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_n    (flag_n),
        .flag_v    (flag_v),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model from the opcode table using plain integer arithmetic
    task automatic model(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] res, output logic [7:0] hi,
                         output logic z, output logic c, output logic n, output logic v,
                         output logic e, output int lat);
        int ua, ub, sa, sb, s, zv;
        bit illegal;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        res = 0; hi = 0; c = 0; v = 0; e = 0; lat = 1; illegal = 0; zv = -1;
        case (op)
            5'd4:  begin res = 8'(ua + ub); c = (ua + ub) > 255; s = sa + sb; v = (s > 127) || (s < -128); end
            5'd5:  begin res = 8'(ua - ub); c = ua < ub; s = sa - sb; v = (s > 127) || (s < -128); end
            5'd6:  res = a & b;
            5'd7:  res = a | b;
            5'd8:  res = a ^ b;
            5'd9:  begin res = 8'(ua * ub); hi = 8'((ua * ub) / 256); lat = 9; end
            5'd10, 5'd11: begin
                if (ub == 0) begin
                    res = 8'hFF; hi = a; e = 1;
                end else begin
                    res = (op == 5'd10) ? 8'(ua / ub) : 8'(ua % ub);
                    hi  = (op == 5'd10) ? 8'(ua % ub) : 8'(ua / ub);
                    lat = 9;
                end
            end
            5'd12: begin res = a; c = ua < ub; s = sa - sb; v = (s > 127) || (s < -128); zv = (ua - ub + 256) % 256; end
            5'd13: res = ~a;
            5'd15: begin res = 8'(ua + 1); c = (ua == 255); v = (sa + 1) > 127; end
            5'd16: begin res = 8'(ua - 1 + 256); c = (ua == 0); v = (sa - 1) < -128; end
            5'd17: begin res = 8'(ua * 2); c = ua >= 128; end
            5'd18: begin res = 8'(ua / 2); c = (ua % 2) == 1; end
            5'd19: res = a;
            default: begin e = 1; illegal = 1; end
        endcase
        if (zv < 0) zv = res;
        z = (zv == 0) && !illegal;
        n = (zv >= 128);
    endtask

    task automatic run_op(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                          input bit disturb, input string tag);
        logic [7:0] e_res, e_hi;
        logic ez, ec, en, ev, ee;
        int e_lat, cyc;
        model(op, a, b, e_res, e_hi, ez, ec, en, ev, ee, e_lat);
        @(negedge clk);
        opcode = op; temp1 = a; temp2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        if (disturb) temp1 = ~a;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (!done && cyc < 16) begin
            @(negedge clk);
            cyc++;
            start = disturb && (cyc == 2 || cyc == 5);
            if (start) begin
                temp1  = 8'($urandom);
                temp2  = 8'($urandom);
                opcode = 5'd4;
            end
        end
        start = 1'b0;
        check({tag, "_lat"}, 32'(cyc), 32'(e_lat));
        check({tag, "_res"}, 32'(result), 32'(e_res));
        check({tag, "_hi"}, 32'(result_hi), 32'(e_hi));
        check({tag, "_zcnv"}, 32'({flag_z, flag_c, flag_n, flag_v}), 32'({ez, ec, en, ev}));
        check({tag, "_err"}, 32'(err), 32'(ee));
        @(negedge clk);
        check({tag, "_after"}, 32'({done, busy, result}), 32'({1'b0, 1'b0, e_res}));
    endtask

    initial begin
        bit saw;
        logic [4:0] op;
        logic [7:0] a, b;
        rst = 1'b1; start = 1'b0; opcode = '0; temp1 = '0; temp2 = '0;
        #1;
        check("reset_outs", 32'({busy, done, result, result_hi, flag_z, flag_c, flag_n, flag_v, err}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(5'd4,  8'h7F, 8'h01, 0, "add_ovf");
        run_op(5'd4,  8'hFF, 8'h01, 0, "add_carry");
        run_op(5'd9,  8'h0F, 8'h11, 0, "mul_0f11");
        run_op(5'd9,  8'hFF, 8'hFF, 0, "mul_ffff");
        run_op(5'd10, 8'h64, 8'h07, 0, "div");
        run_op(5'd11, 8'h64, 8'h07, 0, "mod");
        run_op(5'd10, 8'h64, 8'h00, 0, "div0");
        run_op(5'd11, 8'h64, 8'h00, 0, "mod0");
        run_op(5'd9,  8'hA5, 8'h3C, 1, "mul_hshk");
        run_op(5'd10, 8'hC8, 8'h09, 1, "div_hshk");
        run_op(5'd14, 8'h12, 8'h34, 0, "illegal");
        run_op(5'd17, 8'h81, 8'h00, 0, "shl");
        run_op(5'd12, 8'h05, 8'h05, 0, "cmp_eq");
        run_op(5'd16, 8'h80, 8'h00, 0, "dec_ovf");
        run_op(5'd15, 8'h7F, 8'h00, 0, "inc_ovf");

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        opcode = 5'd9; temp1 = 8'h0F; temp2 = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid", 32'({busy, done, result, result_hi, flag_z, flag_c, flag_n, flag_v, err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) saw = 1;
        end
        check("rst_nodone", 32'(saw), 32'd0);

        for (int i = 0; i < 80; i++) begin
            op = 5'($urandom_range(0, 31));
            a  = 8'($urandom);
            b  = 8'($urandom);
            if (op == 5'd9 && b == 0) b = 8'h01;
            if ((op == 5'd10 || op == 5'd11) && ($urandom % 8 == 0)) b = 8'h00;
            run_op(op, a, b, ($urandom % 4) == 0, $sformatf("rnd%0d_op%0d", i, op));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
